// File: rtl/fold_fir_sequencer.sv
// -----------------------------------------------------------------------------
// fold_fir_sequencer
//
// Address and control sequencer for a folded (single-MAC) FIR filter.
// Each accepted sample goes into a circular buffer in a two-port RAM. The
// block then walks all TAPS taps back-to-back, pairing the newest sample with
// coefficient 0. It carries no data; it only drives addresses and strobes.
//
// Ports:
//   clk        clock
//   nGrst      asynchronous active-low reset
//   rst        synchronous reset (acts even when clkEn is low)
//   clkEn      clock enable; low freezes all state
//   dataValid  one-cycle strobe: a new sample is present this cycle
//   busy       a frame is in progress; new samples are dropped
//   ramWe      RAM write strobe (combinational)
//   ramWAddr   RAM write address (write pointer)
//   ramRe      RAM read enable
//   ramRAddr   RAM read address (read pointer)
//   coefAddr   coefficient ROM address (tap index)
//   macFirst   MAC loads the product instead of accumulating (at MAC input)
//   macEn      MAC operands valid (at MAC input)
//   outValid   one-cycle pulse: MAC output holds a finished result
//   overrun    sticky flag: a sample arrived while busy and was dropped
// -----------------------------------------------------------------------------
module fold_fir_sequencer #(
  parameter int TAPS     = 16,
  parameter int LOGTAPS  = 4,
  parameter int PIPE_DLY = 3,
  parameter int MAC_DLY  = 2
) (
  input  logic               clk,
  input  logic               nGrst,
  input  logic               rst,
  input  logic               clkEn,
  input  logic               dataValid,
  output logic               busy,
  output logic               ramWe,
  output logic [LOGTAPS-1:0] ramWAddr,
  output logic               ramRe,
  output logic [LOGTAPS-1:0] ramRAddr,
  output logic [LOGTAPS-1:0] coefAddr,
  output logic               macFirst,
  output logic               macEn,
  output logic               outValid,
  output logic               overrun
);

  localparam int OUT_DLY = PIPE_DLY + MAC_DLY;
  localparam logic [LOGTAPS-1:0] LAST_TAP = LOGTAPS'(TAPS - 1);
  localparam logic [LOGTAPS-1:0] ONE      = LOGTAPS'(1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]         state_q, state_d;
  logic [LOGTAPS-1:0] k_q, k_d;
  logic [LOGTAPS-1:0] wp_q, wp_d;
  logic [LOGTAPS-1:0] rp_q, rp_d;
  logic               overrun_q, overrun_d;

  // Strobe delay lines: bit 0 takes the raw strobe, the top bit is the output.
  logic [PIPE_DLY-1:0] en_pipe_q, en_pipe_d;
  logic [PIPE_DLY-1:0] first_pipe_q, first_pipe_d;
  logic [OUT_DLY-1:0]  last_pipe_q, last_pipe_d;

  logic run;
  logic last_tap;
  logic accept;

  assign run      = (state_q == S_RUN);
  assign last_tap = run && (k_q == LAST_TAP);
  assign accept   = !run && dataValid && clkEn && !rst;

  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    wp_d         = wp_q;
    rp_d         = rp_q;
    overrun_d    = overrun_q;
    en_pipe_d    = en_pipe_q;
    first_pipe_d = first_pipe_q;
    last_pipe_d  = last_pipe_q;

    if (rst) begin
      // RAM contents are untouched; clearing the delay lines kills any
      // in-flight frame so it never raises outValid.
      state_d      = S_IDLE;
      k_d          = '0;
      wp_d         = '0;
      rp_d         = '0;
      overrun_d    = 1'b0;
      en_pipe_d    = '0;
      first_pipe_d = '0;
      last_pipe_d  = '0;
    end else if (clkEn) begin
      if (!run) begin
        if (dataValid) begin
          state_d = S_RUN;
          k_d     = '0;
          rp_d    = wp_q;
        end
      end else begin
        if (dataValid) begin
          overrun_d = 1'b1;
        end
        // Explicit wrap so non-power-of-two depths work.
        rp_d = (rp_q == '0) ? LAST_TAP : rp_q - ONE;
        if (last_tap) begin
          state_d = S_IDLE;
          k_d     = '0;
          wp_d    = (wp_q == LAST_TAP) ? '0 : wp_q + ONE;
        end else begin
          k_d = k_q + ONE;
        end
      end

      en_pipe_d[0]    = run;
      first_pipe_d[0] = run && (k_q == '0);
      last_pipe_d[0]  = last_tap;
      for (int i = 1; i < PIPE_DLY; i++) begin
        en_pipe_d[i]    = en_pipe_q[i-1];
        first_pipe_d[i] = first_pipe_q[i-1];
      end
      for (int i = 1; i < OUT_DLY; i++) begin
        last_pipe_d[i] = last_pipe_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge nGrst) begin
    if (!nGrst) begin
      state_q      <= S_IDLE;
      k_q          <= '0;
      wp_q         <= '0;
      rp_q         <= '0;
      overrun_q    <= 1'b0;
      en_pipe_q    <= '0;
      first_pipe_q <= '0;
      last_pipe_q  <= '0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      wp_q         <= wp_d;
      rp_q         <= rp_d;
      overrun_q    <= overrun_d;
      en_pipe_q    <= en_pipe_d;
      first_pipe_q <= first_pipe_d;
      last_pipe_q  <= last_pipe_d;
    end
  end

  assign busy     = run;
  assign ramWe    = accept;
  assign ramWAddr = wp_q;
  assign ramRe    = run && clkEn;
  assign ramRAddr = rp_q;
  assign coefAddr = k_q;
  assign macEn    = en_pipe_q[PIPE_DLY-1];
  assign macFirst = first_pipe_q[PIPE_DLY-1];
  assign outValid = last_pipe_q[OUT_DLY-1];
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_fold_fir_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fold_fir_sequencer
//
// Drives two sequencers from the same inputs: one with 16 taps and one with
// 5 taps (non power of two). Each is checked every cycle against a timeline
// model: a frame is just the enabled-edge index at which its sample was
// accepted. Every output follows from that index by plain arithmetic.
// -----------------------------------------------------------------------------
module tb_fold_fir_sequencer;

  localparam int P = 3;
  localparam int M = 2;

  logic clk = 1'b0;
  logic nGrst = 1'b0;
  logic rst = 1'b0;
  logic clkEn = 1'b0;
  logic dataValid = 1'b0;

  always #5 clk = ~clk;

  logic       a_busy, a_we, a_re, a_mf, a_me, a_ov, a_or;
  logic [3:0] a_wa, a_ra, a_ca;
  logic       b_busy, b_we, b_re, b_mf, b_me, b_ov, b_or;
  logic [2:0] b_wa, b_ra, b_ca;

  fold_fir_sequencer #(.TAPS(16), .LOGTAPS(4), .PIPE_DLY(P), .MAC_DLY(M)) dut16 (
    .clk(clk), .nGrst(nGrst), .rst(rst), .clkEn(clkEn), .dataValid(dataValid),
    .busy(a_busy), .ramWe(a_we), .ramWAddr(a_wa), .ramRe(a_re), .ramRAddr(a_ra),
    .coefAddr(a_ca), .macFirst(a_mf), .macEn(a_me), .outValid(a_ov), .overrun(a_or)
  );

  fold_fir_sequencer #(.TAPS(5), .LOGTAPS(3), .PIPE_DLY(P), .MAC_DLY(M)) dut5 (
    .clk(clk), .nGrst(nGrst), .rst(rst), .clkEn(clkEn), .dataValid(dataValid),
    .busy(b_busy), .ramWe(b_we), .ramWAddr(b_wa), .ramRe(b_re), .ramRAddr(b_ra),
    .coefAddr(b_ca), .macFirst(b_mf), .macEn(b_me), .outValid(b_ov), .overrun(b_or)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  // Model state per instance: m counts enabled edges since the last reset;
  // acc holds the edge indices of the four most recent accepts (newest first).
  int taps [2] = '{16, 5};
  int m    [2];
  int wp   [2];
  int wpa  [2];
  int ov   [2];
  int acc  [2][4];

  task automatic chk(input string tag, input logic [31:0] got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset(input int i);
    m[i]   = 0;
    wp[i]  = 0;
    wpa[i] = 0;
    ov[i]  = 0;
    for (int j = 0; j < 4; j++) acc[i][j] = -1000;
  endtask

  function automatic bit m_busy(input int i);
    return (m[i] >= acc[i][0] + 1) && (m[i] <= acc[i][0] + taps[i]);
  endfunction

  task automatic compare_all(input int i, input logic g_busy, input logic g_we,
                             input logic [3:0] g_wa, input logic g_re,
                             input logic [3:0] g_ra, input logic [3:0] g_ca,
                             input logic g_mf, input logic g_me,
                             input logic g_ov, input logic g_or);
    int t, a, off, e_me, e_mf, e_ov;
    bit bsy;
    string pfx;
    t    = taps[i];
    bsy  = m_busy(i);
    pfx  = $sformatf("c%0d T%0d", cyc, t);
    e_me = 0; e_mf = 0; e_ov = 0;
    for (int j = 0; j < 4; j++) begin
      a = acc[i][j];
      if (m[i] >= a + 1 + P && m[i] <= a + t + P) e_me = 1;
      if (m[i] == a + 1 + P) e_mf = 1;
      if (m[i] == a + t + P + M) e_ov = 1;
    end
    chk({pfx, " busy"}, 32'(g_busy), int'(bsy));
    chk({pfx, " ramWe"}, 32'(g_we), int'(dataValid && clkEn && !rst && !bsy));
    chk({pfx, " ramWAddr"}, 32'(g_wa), wp[i]);
    chk({pfx, " ramRe"}, 32'(g_re), int'(bsy && clkEn));
    chk({pfx, " macEn"}, 32'(g_me), e_me);
    chk({pfx, " macFirst"}, 32'(g_mf), e_mf);
    chk({pfx, " outValid"}, 32'(g_ov), e_ov);
    chk({pfx, " overrun"}, 32'(g_or), ov[i]);
    if (bsy) begin
      off = m[i] - acc[i][0] - 1;
      chk({pfx, " ramRAddr"}, 32'(g_ra), ((wpa[i] - off) % t + t) % t);
      chk({pfx, " coefAddr"}, 32'(g_ca), off);
    end
  endtask

  // Advance the model over the coming clock edge using the current inputs.
  task automatic model_step(input int i);
    int t, a;
    bit bsy;
    if (rst) begin
      model_reset(i);
    end else if (clkEn) begin
      t   = taps[i];
      a   = acc[i][0];
      bsy = m_busy(i);
      if (dataValid) begin
        if (bsy) begin
          ov[i] = 1;
        end else begin
          for (int j = 3; j > 0; j--) acc[i][j] = acc[i][j-1];
          acc[i][0] = m[i];
          wpa[i]    = wp[i];
        end
      end
      if (bsy && m[i] == a + t) wp[i] = (wp[i] + 1) % t;
      m[i]++;
    end
  endtask

  task automatic check_both();
    compare_all(0, a_busy, a_we, a_wa, a_re, a_ra, a_ca, a_mf, a_me, a_ov, a_or);
    compare_all(1, b_busy, b_we, {1'b0, b_wa}, b_re, {1'b0, b_ra}, {1'b0, b_ca},
                b_mf, b_me, b_ov, b_or);
  endtask

  task automatic cycle(input bit dv, input bit ce, input bit r);
    @(negedge clk);
    dataValid = dv;
    clkEn     = ce;
    rst       = r;
    #1;
    check_both();
    model_step(0);
    model_step(1);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) cycle(1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    model_reset(0);
    model_reset(1);

    // Reset values while nGrst is held low.
    repeat (3) @(negedge clk);
    #1;
    check_both();
    nGrst = 1'b1;

    // Single frame from a clean start.
    idle(10);
    cycle(1'b1, 1'b1, 1'b0);
    idle(35);

    // Sample arriving mid-frame is dropped and sets overrun; rst clears it.
    cycle(1'b1, 1'b1, 1'b0);
    idle(1);
    cycle(1'b1, 1'b1, 1'b0);
    idle(30);
    cycle(1'b0, 1'b1, 1'b1);
    idle(3);

    // rst mid-frame aborts the frame; the next sample lands at address 0.
    cycle(1'b1, 1'b1, 1'b0);
    idle(4);
    cycle(1'b0, 1'b1, 1'b1);
    idle(10);
    cycle(1'b1, 1'b1, 1'b0);
    idle(30);

    // clkEn gap inside a frame stretches everything by the gap length.
    cycle(1'b1, 1'b1, 1'b0);
    idle(5);
    for (int j = 0; j < 3; j++) cycle(1'b0, 1'b0, 1'b0);
    idle(35);

    // Frames at maximum 16-tap throughput: pointer wrap, no overrun.
    for (int f = 0; f < 25; f++) begin
      cycle(1'b1, 1'b1, 1'b0);
      idle(16);
    end
    idle(10);

    // Randomized traffic with clock-enable gaps and occasional resets.
    for (int j = 0; j < 3000; j++) begin
      cycle(($urandom % 4) == 0, ($urandom % 10) != 0, ($urandom % 200) == 0);
    end
    idle(30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
